// File: rtl/store_buf_pkg.sv
// Shared types, funct3 encodings and lane-formatting helpers for the store write buffer.
package store_buf_pkg;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } lane_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } entry_t;

    // Strobe mask plus byte/half replication so every enabled lane carries the store data.
    function automatic lane_t format_lane(input logic [2:0]  funct3,
                                          input logic [1:0]  off,
                                          input logic [31:0] data);
        lane_t lane;
        lane.wdata = data;
        lane.wstrb = 4'b0000;
        case (funct3)
            F3_SB: begin
                lane.wstrb = 4'b0001 << off;
                lane.wdata = {4{data[7:0]}};
            end
            F3_SH: begin
                lane.wstrb = 4'b0011 << off;
                lane.wdata = {2{data[15:0]}};
            end
            F3_SW: begin
                lane.wstrb = 4'b1111;
                lane.wdata = data;
            end
            default: begin
                lane.wstrb = 4'b0000;
                lane.wdata = data;
            end
        endcase
        return lane;
    endfunction

    function automatic logic lane_illegal(input logic [2:0] funct3,
                                          input logic [1:0] off);
        logic bad;
        case (funct3)
            F3_SB:   bad = 1'b0;
            F3_SH:   bad = off[0];
            F3_SW:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_format.sv
// Combinational store formatter: byte strobes, lane-replicated data and misalignment detection.
import store_buf_pkg::*;

module store_lane_format (
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        illegal
);

    lane_t lane_s;

    // Apply the package helpers to the incoming store.
    always_comb begin
        lane_s  = format_lane(funct3, off, st_data);
        wstrb   = lane_s.wstrb;
        wdata   = lane_s.wdata;
        illegal = lane_illegal(funct3, off);
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the core store path and data memory.
// Optional macro STORE_BUF_LOAD_HAZARD_EN adds a word-address load/store hazard compare.
import store_buf_pkg::*;

module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    input  logic [AW-1:0]          st_addr,
    input  logic [DW-1:0]          st_data,
    input  logic [2:0]             st_funct3,
    output logic                   st_ready,
    output logic                   st_err,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic [3:0]             mem_wstrb,
    output logic                   buf_empty,
    output logic [$clog2(DEPTH):0] buf_count
`ifdef STORE_BUF_LOAD_HAZARD_EN
    ,
    input  logic                   ld_valid,
    input  logic [AW-1:0]          ld_addr,
    output logic                   ld_hazard
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] ZERO_PTR = {PW{1'b0}};
    localparam logic [PW-1:0] ONE_PTR  = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          st_err_r;

    logic [AW-3:0] addr_mem_r [DEPTH];
    lane_t         lane_mem_r [DEPTH];

    logic [3:0]    fmt_wstrb_s;
    logic [31:0]   fmt_wdata_s;
    logic          fmt_illegal_s;
    lane_t         push_lane_s;
    logic          push_s;
    logic          pop_s;
    logic          err_s;

    store_lane_format u_fmt (
        .funct3  (st_funct3),
        .off     (st_addr[1:0]),
        .st_data (st_data),
        .wstrb   (fmt_wstrb_s),
        .wdata   (fmt_wdata_s),
        .illegal (fmt_illegal_s)
    );

    // Status and head-of-queue outputs come only from registered state, never from mem_ready.
    assign st_ready    = (count_r != FULL_CNT);
    assign mem_valid   = (count_r != ZERO_CNT);
    assign buf_empty   = (count_r == ZERO_CNT);
    assign buf_count   = count_r;
    assign st_err      = st_err_r;
    assign mem_addr    = {addr_mem_r[rd_ptr_r], 2'b00};
    assign mem_wdata   = lane_mem_r[rd_ptr_r].wdata;
    assign mem_wstrb   = lane_mem_r[rd_ptr_r].wstrb;
    assign push_lane_s = '{wdata: fmt_wdata_s, wstrb: fmt_wstrb_s};

    // Handshake decode and occupancy update.
    always_comb begin
        push_s      = 1'b0;
        err_s       = 1'b0;
        pop_s       = 1'b0;
        count_nxt_s = count_r;
        if (st_valid && st_ready) begin
            if (fmt_illegal_s) begin
                err_s = 1'b1;
            end else begin
                push_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
            err_s  = 1'b0;
        end
        if (mem_valid && mem_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_CNT;
            2'b01:   count_nxt_s = count_r - ONE_CNT;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, count and error-pulse registers; reset drops every held entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= ZERO_PTR;
            rd_ptr_r <= ZERO_PTR;
            count_r  <= ZERO_CNT;
            st_err_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            count_r  <= count_nxt_s;
            st_err_r <= err_s;
        end
    end

    // Entry storage; not cleared by reset since entries are only read while occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r] <= st_addr[AW-1:2];
            lane_mem_r[wr_ptr_r] <= push_lane_s;
        end
    end

`ifdef STORE_BUF_LOAD_HAZARD_EN
    logic [PW-1:0] rel_s;
    logic          hit_s;

    // Word-address match against occupied slots only (slot distance from head below count).
    always_comb begin
        hit_s = 1'b0;
        rel_s = ZERO_PTR;
        for (int i = 0; i < DEPTH; i++) begin
            rel_s = PW'(i) - rd_ptr_r;
            if (({1'b0, rel_s} < count_r) && (addr_mem_r[i] == ld_addr[AW-1:2])) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
        ld_hazard = ld_valid && hit_s;
    end
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_ready;
    logic        st_err;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        buf_empty;
    logic [2:0]  buf_count;
`ifdef STORE_BUF_LOAD_HAZARD_EN
    logic        ld_hazard;
`endif

    always #5 clk = ~clk;

    store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_funct3 (st_funct3),
        .st_ready  (st_ready),
        .st_err    (st_err),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .buf_empty (buf_empty),
        .buf_count (buf_count)
`ifdef STORE_BUF_LOAD_HAZARD_EN
        ,
        .ld_valid  (1'b0),
        .ld_addr   (32'h0),
        .ld_hazard (ld_hazard)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t q[$];
    logic exp_err;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reference formatting from the architectural store rules, using arithmetic replication.
    function automatic bit model_fmt(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] d, output exp_t e);
        int off;
        bit legal;
        off    = int'(a % 32'd4);
        e.addr = a - 32'(off);
        e.wdata = d;
        e.wstrb = 4'b0000;
        case (f3)
            3'd0: begin
                legal   = 1'b1;
                e.wstrb = 4'(1 << off);
                e.wdata = 32'(d[7:0]) * 32'h01010101;
            end
            3'd1: begin
                legal   = (off % 2 == 0);
                e.wstrb = 4'(3 << off);
                e.wdata = 32'(d[15:0]) * 32'h00010001;
            end
            3'd2: begin
                legal   = (off == 0);
                e.wstrb = 4'b1111;
                e.wdata = d;
            end
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    task automatic do_cycle();
        exp_t e;
        bit   legal;
        bit   push;
        bit   pop;
        bit   err;
        chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
        chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
        chk("buf_count", 32'(buf_count), 32'(q.size()));
        chk("buf_empty", 32'(buf_empty), 32'(q.size() == 0));
        chk("st_err", 32'(st_err), 32'(exp_err));
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].addr);
            chk("mem_wdata", mem_wdata, q[0].wdata);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(q[0].wstrb));
        end
        legal = model_fmt(st_funct3, st_addr, st_data, e);
        push  = st_valid && (q.size() < DEPTH) && legal;
        err   = st_valid && (q.size() < DEPTH) && !legal;
        pop   = (q.size() != 0) && mem_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            exp_err = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            exp_err = err;
        end
    endtask

    task automatic set_st(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        st_valid  = v;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b0;
        set_st(1'b0, 3'd0, 32'h0, 32'h0);
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_mvalid", 32'(mem_valid), 32'd0);
        chk("rst_empty", 32'(buf_empty), 32'd1);
        chk("rst_count", 32'(buf_count), 32'd0);
        chk("rst_err", 32'(st_err), 32'd0);

        // SW at 0x104, popped immediately
        mem_ready = 1'b1;
        set_st(1'b1, 3'd2, 32'h104, 32'hDEADBEEF);
        do_cycle();
        set_st(1'b0, 3'd0, 32'h0, 32'h0);
        chk("sw_valid", 32'(mem_valid), 32'd1);
        chk("sw_addr", mem_addr, 32'h104);
        chk("sw_wstrb", 32'(mem_wstrb), 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        do_cycle();
        chk("sw_empty", 32'(buf_empty), 32'd1);

        // SB then SH lane formatting
        mem_ready = 1'b0;
        set_st(1'b1, 3'd0, 32'h103, 32'h000000A5);
        do_cycle();
        set_st(1'b1, 3'd1, 32'h202, 32'h00001234);
        do_cycle();
        set_st(1'b0, 3'd0, 32'h0, 32'h0);
        chk("sb_addr", mem_addr, 32'h100);
        chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        mem_ready = 1'b1;
        do_cycle();
        chk("sh_addr", mem_addr, 32'h200);
        chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
        chk("sh_wdata", mem_wdata, 32'h12341234);
        do_cycle();

        // Fill with stalled memory, fifth store refused
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_st(1'b1, 3'd2, 32'h300 + 32'(4 * i), $urandom);
            do_cycle();
            if (i == 3) chk("full_ready", 32'(st_ready), 32'd0);
        end
        chk("full_count", 32'(buf_count), 32'd4);
        set_st(1'b1, 3'd2, 32'h400, 32'h0BADF00D);
        mem_ready = 1'b1;
        do_cycle();
        chk("full_pop_count", 32'(buf_count), 32'd3);
        mem_ready = 1'b0;
        do_cycle();
        chk("retry_count", 32'(buf_count), 32'd4);
        set_st(1'b0, 3'd0, 32'h0, 32'h0);
        mem_ready = 1'b1;
        repeat (4) do_cycle();
        chk("drain_empty", 32'(buf_empty), 32'd1);

        // Misaligned SW and illegal funct3
        set_st(1'b1, 3'd2, 32'h102, 32'h11111111);
        do_cycle();
        set_st(1'b0, 3'd0, 32'h0, 32'h0);
        chk("misal_err", 32'(st_err), 32'd1);
        chk("misal_count", 32'(buf_count), 32'd0);
        do_cycle();
        chk("misal_err_clr", 32'(st_err), 32'd0);
        set_st(1'b1, 3'd3, 32'h100, 32'h22222222);
        do_cycle();
        set_st(1'b0, 3'd0, 32'h0, 32'h0);
        chk("f3_err", 32'(st_err), 32'd1);
        chk("f3_count", 32'(buf_count), 32'd0);
        do_cycle();
        chk("f3_err_clr", 32'(st_err), 32'd0);

        // Reset during a draining handshake with three entries held
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_st(1'b1, 3'd0, 32'h500 + 32'(i), 32'(i + 8'h40));
            do_cycle();
        end
        set_st(1'b0, 3'd0, 32'h0, 32'h0);
        chk("pre_rst_count", 32'(buf_count), 32'd3);
        rst = 1'b1;
        mem_ready = 1'b1;
        do_cycle();
        rst = 1'b0;
        chk("post_rst_count", 32'(buf_count), 32'd0);
        chk("post_rst_mvalid", 32'(mem_valid), 32'd0);
        chk("post_rst_ready", 32'(st_ready), 32'd1);
        repeat (3) do_cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            a = $urandom;
            if ($urandom_range(0, 9) < 8) f3 = 3'($urandom_range(0, 2));
            else f3 = 3'($urandom_range(3, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (f3 == 3'd2) a = a & 32'hFFFFFFFC;
                else if (f3 == 3'd1) a = a & 32'hFFFFFFFE;
            end
            set_st(1'($urandom_range(0, 2) != 0), f3, a, $urandom);
            mem_ready = 1'($urandom_range(0, 2) != 0);
            rst = 1'($urandom_range(0, 99) == 0);
            do_cycle();
        end
        rst = 1'b0;
        set_st(1'b0, 3'd0, 32'h0, 32'h0);
        mem_ready = 1'b1;
        repeat (DEPTH + 1) do_cycle();
        chk("final_empty", 32'(buf_empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
